ss_signed_s2b: RTL
==================

# ss_signed_s2b

Stochastic-to-binary decoder for sign-magnitude stochastic streams such as those produced by the signed stochastic add/sub tree. It integrates a per-clock (magnitude, sign) bit pair over a fixed window of 2^WINDOW_LOG2 accepted samples. At the end of each window it emits a two's-complement signed count with a one-cycle VALID pulse. It sits at the output of the stochastic neural-network datapath, where it converts neuron/accumulator streams back to binary for readout or the next binary stage.

## Interface
- WINDOW_LOG2, 8, log2 of the window length in accepted samples; legal range 1..16.
- OUT_W, WINDOW_LOG2+2, width of VALUE; holds -2^WINDOW_LOG2..+2^WINDOW_LOG2.

- CLK  in  1  clock; all state changes on rising edge.
- INIT_N  in  1  asynchronous active-low reset.
- START  in  1  begins a window when sampled high in IDLE; ignored otherwise.
- EN  in  1  sample qualifier; IN/SIGN are accepted only on edges with EN=1.
- IN  in  1  stochastic magnitude bit.
- SIGN  in  1  sign of the current IN bit; 1 = negative.
- VALUE  out  OUT_W  signed result of the last completed window; holds until the next completion.
- VALID  out  1  one-cycle pulse; VALUE is updated together with it.
- BUSY  out  1  high while a window is in progress.

## Operation
- Reset (INIT_N=0, asynchronous): state=IDLE, accumulator=0, sample counter=0, VALUE=0, VALID=0, BUSY=0. Takes effect immediately, including mid-window; the partial window is discarded and no VALID is produced.
- States: IDLE, ACCUM.
- IDLE: on an edge with START=1:
  - clear the accumulator and the counter;
  - go to ACCUM and set BUSY=1.
  - The START edge itself does not sample IN.
- ACCUM: on each edge with EN=1:
  - delta = +1 if IN=1 and SIGN=0; -1 if IN=1 and SIGN=1; 0 if IN=0 (SIGN is ignored when IN=0);
  - accumulator += delta;
  - counter += 1.
- ACCUM on an edge with EN=0: accumulator, counter and state hold. The window stretches; stalls are not counted as samples.
- Window completion: on the accepted edge where counter == 2^WINDOW_LOG2-1:
  - VALUE <= accumulator+delta and VALID <= 1 for one cycle;
  - counter <= 0;
  - state -> IDLE and BUSY <= 0 (default build).
- START in ACCUM is ignored, including on the completion edge.
- START is honoured on the edge immediately after completion, with no gap cycle required.
- Arithmetic: the accumulator is OUT_W bits signed and can never overflow, since |sum| <= 2^WINDOW_LOG2 < 2^(OUT_W-1). No saturation logic is built.
- The counter is WINDOW_LOG2 bits and wraps naturally to 0 at completion.

## Timing
- START sampled at edge E0. Accepted samples occur at the next 2^WINDOW_LOG2 edges with EN=1; with EN held high these are E1..E(2^WINDOW_LOG2).
- VALID and the new VALUE are visible after the edge of the last accepted sample. With EN=1 throughout, they are visible after edge E(2^WINDOW_LOG2), i.e. latency is 2^WINDOW_LOG2 cycles from the START edge.
- BUSY rises after E0 and falls after the completion edge, in the same cycle VALID rises.
- VALID is never high for two consecutive cycles in the default build.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Configuration
- SS_S2B_CONTINUOUS_EN defined:
  - after the first START, windows run back-to-back until reset;
  - at completion, state stays ACCUM and the accumulator restarts at 0, so the next window's first sample is the very next accepted edge;
  - BUSY stays 1 and VALID pulses once every 2^WINDOW_LOG2 accepted samples;
  - further START pulses are ignored.
- SS_S2B_CONTINUOUS_EN undefined: single-shot behaviour as described above; each window requires its own START.

## Test plan
- WINDOW_LOG2=4, EN=1, IN=1, SIGN=0 for 16 cycles after START -> VALID at cycle 16 after START with VALUE=+16 (6'sb010000); BUSY falls in the same cycle.
- Same setup with SIGN=1 -> VALUE=-16 (6'sb110000). Same setup with IN=0 and SIGN toggling -> VALUE=0.
- IN=1 with SIGN alternating 0/1 for 16 samples -> VALUE=0. Pattern of 12 positive and 4 negative samples -> VALUE=+8.
- EN low for 5 cycles in mid-window while IN=1, SIGN=0 -> VALID delayed to cycle 21 after START; VALUE=+16. START pulsed at cycle 7 -> ignored, no extra VALID.
- INIT_N pulsed low at cycle 9 of a window -> BUSY, VALID and VALUE go to 0 immediately. START at cycle 12 produces a clean full window; the result excludes pre-reset samples.
- With SS_S2B_CONTINUOUS_EN, WINDOW_LOG2=4: a single START followed by 48 cycles of constant input -> VALID at cycles 16, 32 and 48, each with the same VALUE; BUSY stays 1 throughout.

Source files
------------

// File: rtl/ss_signed_s2b.sv
// ss_signed_s2b: stochastic-to-binary decoder for sign-magnitude streams.
//
// Integrates a per-clock (magnitude, sign) bit pair over a window of 2^WINDOW_LOG2 accepted
// samples and emits a two's-complement count with a one-cycle valid pulse.
//
// Ports:
//   clk    in   clock, rising edge
//   init_n in   asynchronous active-low reset
//   start  in   begins a window when sampled high in idle
//   en     in   sample qualifier; in/sign accepted only when en=1
//   in     in   stochastic magnitude bit
//   sign   in   sign of the current in bit (1 = negative)
//   value  out  signed result of the last completed window (OUT_W bits)
//   valid  out  one-cycle pulse, coincident with a new value
//   busy   out  high while a window is in progress
//
// Optional feature: define SS_S2B_CONTINUOUS_EN to run windows back-to-back after the
// first start until reset.

module ss_signed_s2b #(
  parameter int unsigned WINDOW_LOG2 = 8,
  parameter int unsigned OUT_W       = WINDOW_LOG2 + 2
) (
  input  logic             clk,
  input  logic             init_n,
  input  logic             start,
  input  logic             en,
  input  logic             in,
  input  logic             sign,
  output logic [OUT_W-1:0] value,
  output logic             valid,
  output logic             busy
);

  localparam logic StIdle  = 1'b0;
  localparam logic StAccum = 1'b1;

  logic                   state_q, state_d;
  logic [OUT_W-1:0]       acc_q, acc_d;
  logic [WINDOW_LOG2-1:0] cnt_q, cnt_d;
  logic [OUT_W-1:0]       value_q, value_d;
  logic                   valid_q, valid_d;

  logic [OUT_W-1:0]       delta;
  logic [OUT_W-1:0]       sum;
  logic                   last_sample;

  // Sign is irrelevant when the magnitude bit is zero.
  always_comb begin
    delta = '0;
    if (in) begin
      delta = sign ? {OUT_W{1'b1}} : OUT_W'(1);
    end
  end

  // |sum| never exceeds 2^WINDOW_LOG2, so the OUT_W-bit add cannot overflow.
  assign sum         = acc_q + delta;
  assign last_sample = &cnt_q;

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    value_d = value_q;
    valid_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          acc_d   = '0;
          cnt_d   = '0;
          state_d = StAccum;
        end
      end
      StAccum: begin
        if (en) begin
          acc_d = sum;
          cnt_d = cnt_q + 1'b1;
          if (last_sample) begin
            value_d = sum;
            valid_d = 1'b1;
            acc_d   = '0;
`ifdef SS_S2B_CONTINUOUS_EN
            state_d = StAccum;
`else
            state_d = StIdle;
`endif
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge init_n) begin
    if (!init_n) begin
      state_q <= StIdle;
      acc_q   <= '0;
      cnt_q   <= '0;
      value_q <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      value_q <= value_d;
      valid_q <= valid_d;
    end
  end

  assign value = value_q;
  assign valid = valid_q;
  assign busy  = (state_q == StAccum);

endmodule
